// File: rtl/icosoc_tonegen_pkg.sv
// Shared definitions for the tone generator: register map, field widths,
// CTRL/STATUS bit positions and the bus-acknowledge state encoding.
package icosoc_tonegen_pkg;

  localparam int unsigned PERIOD_W  = 16;   // half-period in microseconds
  localparam int unsigned DUR_W     = 16;   // note duration in milliseconds
  localparam int unsigned US_PER_MS = 1000;

  // Register offset within a channel, taken from ctrl_addr[3:2]
  typedef enum logic [1:0] {
    REG_PERIOD   = 2'd0,
    REG_DURATION = 2'd1,
    REG_CTRL     = 2'd2,
    REG_STATUS   = 2'd3
  } reg_sel_e;

  localparam int unsigned CTRL_EN_BIT     = 0;
  localparam int unsigned STAT_ACTIVE_BIT = 0;
  localparam int unsigned STAT_DONE_BIT   = 1;

  typedef enum logic {
    ACC_IDLE,
    ACC_ACK
  } acc_state_e;

endpackage

// File: rtl/icosoc_mod_tonegen_if.sv
// Control bus of the tone generator.
//   ctrl_wr   : per-byte write strobes
//   ctrl_rd   : read strobe
//   ctrl_addr : byte address, [7:4] channel, [3:2] register
//   ctrl_wdat : write data
//   ctrl_rdat : read data, valid only in the ctrl_done cycle
//   ctrl_done : one-cycle access acknowledge
interface icosoc_mod_tonegen_if;
  logic [3:0]  ctrl_wr;
  logic        ctrl_rd;
  logic [15:0] ctrl_addr;
  logic [31:0] ctrl_wdat;
  logic [31:0] ctrl_rdat;
  logic        ctrl_done;

  modport master (
    output ctrl_wr, ctrl_rd, ctrl_addr, ctrl_wdat,
    input  ctrl_rdat, ctrl_done
  );

  modport slave (
    input  ctrl_wr, ctrl_rd, ctrl_addr, ctrl_wdat,
    output ctrl_rdat, ctrl_done
  );
endinterface

// File: rtl/tonegen_channel.sv
// One tone channel: PERIOD/DURATION/enable/done registers, phase counter,
// remaining-duration counter and the registered square-wave output.
//   clk, reset            : clock, asynchronous active-high reset
//   us_tick, ms_tick      : shared timebase strobes
//   wstrb, wdat           : byte strobes [1:0] and data [15:0] of a bus write
//   wr_period/wr_duration : write the PERIOD / DURATION register
//   wr_ctrl               : write CTRL (byte 0 strobe already qualified)
//   clr_done              : write-1-to-clear of the done flag
//   period .. done        : register values for readback
//   tone                  : square-wave output
module tonegen_channel
  import icosoc_tonegen_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                us_tick,
  input  logic                ms_tick,
  input  logic [1:0]          wstrb,
  input  logic [PERIOD_W-1:0] wdat,
  input  logic                wr_period,
  input  logic                wr_duration,
  input  logic                wr_ctrl,
  input  logic                clr_done,
  output logic [PERIOD_W-1:0] period,
  output logic [DUR_W-1:0]    duration,
  output logic                enable,
  output logic                active,
  output logic                done,
  output logic                tone
);

  logic [PERIOD_W-1:0] period_q, cnt_q, period_new;
  logic [DUR_W-1:0]    dur_q, rem_q, dur_new;
  logic                en_q, done_q, tone_q, active_w;

  assign period_new = {wstrb[1] ? wdat[15:8] : period_q[15:8],
                       wstrb[0] ? wdat[7:0]  : period_q[7:0]};
  assign dur_new    = {wstrb[1] ? wdat[15:8] : dur_q[15:8],
                       wstrb[0] ? wdat[7:0]  : dur_q[7:0]};
  assign active_w   = en_q && (period_q != '0);

  // Later assignments in this block take priority: bus writes override the
  // tone/duration engine when they land in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_q <= '0;
      dur_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      en_q     <= 1'b0;
      done_q   <= 1'b0;
      tone_q   <= 1'b0;
    end else begin
      if (!active_w) begin
        cnt_q  <= '0;
        tone_q <= 1'b0;
      end else if (us_tick) begin
        if (cnt_q == period_q - 1'b1) begin
          cnt_q  <= '0;
          tone_q <= ~tone_q;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end

      // rem 0 is treated like 1 so a stale zero can never wrap around
      if (active_w && (dur_q != '0) && ms_tick) begin
        if (rem_q <= DUR_W'(1)) begin
          en_q   <= 1'b0;
          tone_q <= 1'b0;
          cnt_q  <= '0;
          rem_q  <= '0;
          done_q <= 1'b1;
        end else begin
          rem_q <= rem_q - 1'b1;
        end
      end

      if (wr_period) begin
        period_q <= period_new;
        cnt_q    <= '0;
      end

      if (wr_duration) begin
        dur_q <= dur_new;
        if (en_q) rem_q <= dur_new;
      end

      if (wr_ctrl) begin
        en_q <= wdat[CTRL_EN_BIT];
        if (!wdat[CTRL_EN_BIT]) begin
          tone_q <= 1'b0;
          cnt_q  <= '0;
        end else if (!en_q) begin
          rem_q  <= dur_q;
          done_q <= 1'b0;
          tone_q <= 1'b0;
          cnt_q  <= '0;
        end
      end

      if (clr_done) done_q <= 1'b0;
    end
  end

  assign period   = period_q;
  assign duration = dur_q;
  assign enable   = en_q;
  assign active   = active_w;
  assign done     = done_q;
  assign tone     = tone_q;

endmodule

// File: rtl/icosoc_mod_tonegen.sv
// Multi-channel square-wave tone generator with a register bus.
//   clk      : system clock
//   reset    : asynchronous active-high reset
//   ctrl     : register bus (slave side), see icosoc_mod_tonegen_if
//   tone_out : per-channel square-wave outputs, registered
// The top holds the shared us/ms prescalers, the bus decode and the
// acknowledge FSM; each channel lives in tonegen_channel.
module icosoc_mod_tonegen
  import icosoc_tonegen_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned CLK_F_MHZ = 20
) (
  input  logic                 clk,
  input  logic                 reset,
  icosoc_mod_tonegen_if.slave  ctrl,
  output logic [NUM_CH-1:0]    tone_out
);

  localparam int unsigned PRE_W = $clog2(CLK_F_MHZ);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_F_MHZ - 1);
  localparam logic [9:0]       MS_LAST  = 10'(US_PER_MS - 1);

  logic [PRE_W-1:0] pre_q;
  logic [9:0]       ms_q;
  logic             us_tick, ms_tick;

  assign us_tick = (pre_q == PRE_LAST);
  assign ms_tick = us_tick && (ms_q == MS_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q <= '0;
      ms_q  <= '0;
    end else begin
      pre_q <= us_tick ? '0 : pre_q + 1'b1;
      if (us_tick) ms_q <= ms_tick ? '0 : ms_q + 1'b1;
    end
  end

  // Access acknowledge: a request is taken only from IDLE, so a request
  // still held during the ACK cycle is ignored for that cycle.
  acc_state_e state_q, state_d;
  logic       req, accept;

  assign req = (|ctrl.ctrl_wr) | ctrl.ctrl_rd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ACC_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = ACC_IDLE;
    accept  = 1'b0;
    if (state_q == ACC_IDLE && req) begin
      state_d = ACC_ACK;
      accept  = 1'b1;
    end
  end

  logic [3:0] ch_idx;
  reg_sel_e   reg_sel;
  logic       page_ok, do_wr, do_rd;

  assign ch_idx  = ctrl.ctrl_addr[7:4];
  assign reg_sel = reg_sel_e'(ctrl.ctrl_addr[3:2]);
  assign page_ok = (ctrl.ctrl_addr[15:8] == 8'h00);
  assign do_wr   = accept && (|ctrl.ctrl_wr) && page_ok;
  assign do_rd   = accept && ctrl.ctrl_rd;

  logic unused_bits;
  assign unused_bits = ^{ctrl.ctrl_wdat[31:16], ctrl.ctrl_addr[1:0]};

  logic [PERIOD_W-1:0] ch_period [NUM_CH];
  logic [DUR_W-1:0]    ch_dur    [NUM_CH];
  logic [NUM_CH-1:0]   ch_en, ch_active, ch_done;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic sel, wr_lo;
    assign sel   = do_wr && (ch_idx == 4'(i));
    assign wr_lo = |ctrl.ctrl_wr[1:0];

    tonegen_channel u_ch (
      .clk         (clk),
      .reset       (reset),
      .us_tick     (us_tick),
      .ms_tick     (ms_tick),
      .wstrb       (ctrl.ctrl_wr[1:0]),
      .wdat        (ctrl.ctrl_wdat[15:0]),
      .wr_period   (sel && wr_lo && reg_sel == REG_PERIOD),
      .wr_duration (sel && wr_lo && reg_sel == REG_DURATION),
      .wr_ctrl     (sel && ctrl.ctrl_wr[0] && reg_sel == REG_CTRL),
      .clr_done    (sel && ctrl.ctrl_wr[0] && reg_sel == REG_STATUS &&
                    ctrl.ctrl_wdat[STAT_DONE_BIT]),
      .period      (ch_period[i]),
      .duration    (ch_dur[i]),
      .enable      (ch_en[i]),
      .active      (ch_active[i]),
      .done        (ch_done[i]),
      .tone        (tone_out[i])
    );
  end

  // Channels at or beyond NUM_CH never match, so they read as zero
  logic [31:0] rd_val;
  always_comb begin
    rd_val = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (page_ok && ch_idx == 4'(i)) begin
        case (reg_sel)
          REG_PERIOD:   rd_val = 32'(ch_period[i]);
          REG_DURATION: rd_val = 32'(ch_dur[i]);
          REG_CTRL:     rd_val[CTRL_EN_BIT] = ch_en[i];
          REG_STATUS: begin
            rd_val[STAT_ACTIVE_BIT] = ch_active[i];
            rd_val[STAT_DONE_BIT]   = ch_done[i];
          end
        endcase
      end
    end
  end

  logic [31:0] rdat_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rdat_q <= '0;
    else       rdat_q <= do_rd ? rd_val : '0;
  end

  assign ctrl.ctrl_rdat = rdat_q;
  assign ctrl.ctrl_done = (state_q == ACC_ACK);

endmodule
